// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one slow memory between I-side and D-side line requests.
// D-side has priority; a starvation counter forces an I grant after STARVE_MAX back-to-back D wins.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_read,
  input  logic         i_write,
  input  logic [27:0]  i_addr,
  input  logic [127:0] i_wdata,
  output logic [127:0] i_rdata,
  output logic         i_ready,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [27:0]  d_addr,
  input  logic [127:0] d_wdata,
  output logic [127:0] d_rdata,
  output logic         d_ready,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic         busy,
  output logic         owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [27:0]  r_addr;
  logic [127:0] r_wdata;
  logic         r_write;
  logic         r_owner;
  logic [3:0]   r_starve_cnt;

  logic w_i_pend;
  logic w_d_pend;
  logic w_starved;
  logic w_grant_i;
  logic w_grant_d;
  logic w_in_busy;

  always_comb begin
    w_i_pend  = i_read | i_write;
    w_d_pend  = d_read | d_write;
    w_starved = (r_starve_cnt == 4'(STARVE_MAX));
    w_grant_d = (r_state == IDLE) & w_d_pend & ~(w_i_pend & w_starved);
    w_grant_i = (r_state == IDLE) & w_i_pend & ~w_grant_d;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_grant_d)      w_next = BUSY_D;
        else if (w_grant_i) w_next = BUSY_I;
      end
      BUSY_I:  if (mem_ready) w_next = RELEASE;
      BUSY_D:  if (mem_ready) w_next = RELEASE;
      RELEASE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A simultaneous read+write from one requester is latched as a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_owner <= 1'b0;
    end else if (w_grant_d) begin
      r_addr  <= d_addr;
      r_wdata <= d_wdata;
      r_write <= d_write;
      r_owner <= 1'b1;
    end else if (w_grant_i) begin
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
      r_write <= i_write;
      r_owner <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_grant_i) begin
      r_starve_cnt <= '0;
    end else if (w_grant_d && w_i_pend && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  always_comb begin
    w_in_busy = (r_state == BUSY_I) | (r_state == BUSY_D);
    mem_read  = w_in_busy & ~r_write;
    mem_write = w_in_busy & r_write;
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    busy      = (r_state != IDLE);
    owner     = r_owner;
    i_ready   = mem_ready & (r_state == BUSY_I);
    d_ready   = mem_ready & (r_state == BUSY_D);
    i_rdata   = mem_rdata;
    d_rdata   = mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences,
// and randomized traffic checked against a transaction-level arbitration model.
module tb_mem_arbiter;

  localparam int unsigned SMAX = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_read, i_write, d_read, d_write;
  logic [27:0]  i_addr, d_addr, mem_addr;
  logic [127:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic         i_ready, d_ready, mem_read, mem_write, mem_ready, busy, owner;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic ir, iw, dr, dw;
    logic eb, eo, erd, ewr;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {i_read, i_write, d_read, d_write, mem_ready} = '0;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0; mem_rdata = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Serve n grants with both sides held; exp_own bit g is the expected owner of grant g.
  // Between grants the next request must appear exactly 3 cycles after mem_ready.
  task automatic run_grants(input int n, input logic [9:0] exp_own, input string tag);
    for (int g = 0; g < n; g++) begin
      int w = 0;
      while (!(mem_read | mem_write) && w < 20) begin
        tick();
        w++;
      end
      if (w >= 20) chk({tag, "_timeout"}, 1, 0);
      if (g > 0) chk({tag, "_gap"}, 128'(w), 2);
      chk({tag, "_owner"}, owner, exp_own[g]);
      chk({tag, "_addr"}, mem_addr, exp_own[g] ? d_addr : i_addr);
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      mem_ready = 1'b1;
      #1;
      chk({tag, "_ready"}, {i_ready, d_ready}, {~exp_own[g], exp_own[g]});
      tick();
      mem_ready = 1'b0;
      chk({tag, "_release"}, {busy, mem_read, mem_write}, 3'b100);
    end
  endtask

  vec_t tbl [8];

  // Random-traffic model state
  logic         ip, dp, i_w, d_w, i_r, d_r;
  logic         txn, txn_own, txn_wr, rel_own;
  logic [27:0]  txn_addr;
  logic [127:0] txn_wd;
  int           ready_at, idle_at, rel_at, mcnt;

  initial begin
    tbl[0] = 8'b1000_1010;  // I read
    tbl[1] = 8'b0100_1001;  // I write
    tbl[2] = 8'b1100_1001;  // I read+write -> write
    tbl[3] = 8'b0010_1110;  // D read
    tbl[4] = 8'b0001_1101;  // D write
    tbl[5] = 8'b0011_1101;  // D read+write -> write
    tbl[6] = 8'b1001_1101;  // both pending -> D first
    tbl[7] = 8'b0000_0000;  // nothing pending

    // Reset state
    rst_n = 1'b0;
    {i_read, i_write, d_read, d_write, mem_ready} = '0;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0; mem_rdata = '0;
    #3;
    chk("reset_ctl", {busy, owner, mem_read, mem_write, i_ready, d_ready}, 6'b0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wdata", mem_wdata, 0);

    // Vector table: single transaction from IDLE
    for (int k = 0; k < 8; k++) begin
      vec_t v;
      v = tbl[k];
      do_reset();
      i_addr  = 28'h0000010 + 28'(k);
      d_addr  = 28'h0000020 + 28'(k);
      i_wdata = {32'hCAFE0000, 96'(k)};
      d_wdata = {16{8'hA5}};
      {i_read, i_write, d_read, d_write} = {v.ir, v.iw, v.dr, v.dw};
      tick();
      chk("tbl_ctl", {busy, mem_read, mem_write}, {v.eb, v.erd, v.ewr});
      if (v.eb) begin
        chk("tbl_owner", owner, v.eo);
        chk("tbl_addr", mem_addr, v.eo ? d_addr : i_addr);
        chk("tbl_wdata", mem_wdata, v.eo ? d_wdata : i_wdata);
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        mem_ready = 1'b1;
        #1;
        chk("tbl_ready", {i_ready, d_ready}, {~v.eo, v.eo});
        chk("tbl_rdata", v.eo ? d_rdata : i_rdata, mem_rdata);
        tick();
        mem_ready = 1'b0;
        {i_read, i_write, d_read, d_write} = '0;
        chk("tbl_release", {busy, mem_read, mem_write}, 3'b100);
        tick();
        chk("tbl_idle", busy, 1'b0);
      end
    end

    // Simultaneous I read / D write; D address changes while busy must not leak through
    do_reset();
    i_addr = 28'h0000010; i_read = 1'b1;
    d_addr = 28'h0000020; d_wdata = {16{8'hA5}}; d_write = 1'b1;
    tick();
    chk("sim_dwrite", {owner, mem_write, mem_read}, 3'b110);
    d_addr = 28'h0000FFF; d_wdata = '0;
    tick(); tick();
    chk("hold_addr", mem_addr, 28'h0000020);
    chk("hold_wdata", mem_wdata, {16{8'hA5}});
    mem_ready = 1'b1;
    #1;
    chk("sim_dready", {i_ready, d_ready}, 2'b01);
    tick();
    mem_ready = 1'b0; d_write = 1'b0;
    chk("sim_release", {busy, mem_read, mem_write}, 3'b100);
    tick();
    chk("sim_gap_idle", {busy, mem_read}, 2'b00);
    tick();
    chk("sim_i_next", {owner, mem_read, mem_addr}, {2'b01, 28'h0000010});
    mem_ready = 1'b1;
    #1;
    chk("sim_iready", {i_ready, d_ready}, 2'b10);
    tick();
    mem_ready = 1'b0; i_read = 1'b0;
    tick();
    // mem_ready while IDLE is ignored
    mem_ready = 1'b1;
    #1;
    chk("idle_ready", {i_ready, d_ready}, 2'b00);
    tick();
    chk("idle_stay", busy, 1'b0);
    mem_ready = 1'b0;

    // Starvation bound: D,D,D,D,I,D,D,D,D,I
    do_reset();
    i_addr = 28'h0000010; d_addr = 28'h0000020;
    i_read = 1'b1; d_read = 1'b1;
    run_grants(10, 10'b0111101111, "starve");

    // Reset during BUSY_D with starve count at its limit; counter must come back cleared
    do_reset();
    i_addr = 28'h0000010; d_addr = 28'h0000020;
    i_read = 1'b1; d_read = 1'b1;
    run_grants(3, 10'b111, "pre_rst");
    begin
      int w = 0;
      while (!mem_read && w < 20) begin tick(); w++; end
      chk("pre_rst_busyd", {busy, owner}, 2'b11);
    end
    mem_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl", {busy, owner, mem_read, mem_write, i_ready, d_ready}, 6'b0);
    chk("rst_mid_addr", mem_addr, 0);
    chk("rst_mid_wdata", mem_wdata, 0);
    mem_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_cnt_cleared", {owner, mem_read}, 2'b11);
    do_reset();
    i_addr = 28'h0000123; i_read = 1'b1;
    tick();
    chk("rst_fresh_i", {busy, owner, mem_read, mem_addr}, {3'b101, 28'h0000123});
    i_read = 1'b0;

    // Randomized traffic against a transaction-level model
    do_reset();
    ip = 0; dp = 0; i_r = 0; i_w = 0; d_r = 0; d_w = 0;
    txn = 0; txn_own = 0; txn_wr = 0; rel_own = 0; txn_addr = '0; txn_wd = '0;
    ready_at = -10; idle_at = 0; rel_at = -10; mcnt = 0;
    for (int c = 1; c <= 1500; c++) begin
      logic eb, erd, ewr, eo;
      tick();
      eb = 0; erd = 0; ewr = 0; eo = 0;
      if (txn) begin
        eb = 1; erd = ~txn_wr; ewr = txn_wr; eo = txn_own;
      end else if (c == rel_at) begin
        eb = 1; eo = rel_own;
      end
      chk("rnd_ctl", {busy, mem_read, mem_write}, {eb, erd, ewr});
      if (eb) chk("rnd_owner", owner, eo);
      if (txn) begin
        chk("rnd_addr", mem_addr, txn_addr);
        chk("rnd_wdata", mem_wdata, txn_wd);
      end

      if (!ip && $urandom_range(0, 2) == 0) begin
        int op = int'($urandom_range(0, 3));
        ip = 1; i_r = (op != 2); i_w = (op >= 2);
        i_addr = 28'($urandom); i_wdata = {$urandom, $urandom, $urandom, $urandom};
      end else if (ip && $urandom_range(0, 3) == 0) begin
        i_addr = 28'($urandom); i_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!dp && $urandom_range(0, 2) == 0) begin
        int op = int'($urandom_range(0, 3));
        dp = 1; d_r = (op != 2); d_w = (op >= 2);
        d_addr = 28'($urandom); d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end else if (dp && $urandom_range(0, 3) == 0) begin
        d_addr = 28'($urandom); d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      i_read = ip & i_r; i_write = ip & i_w;
      d_read = dp & d_r; d_write = dp & d_w;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      mem_ready = txn ? (c == ready_at) : ($urandom_range(0, 4) == 0);
      #1;
      chk("rnd_ready", {i_ready, d_ready},
          {txn && c == ready_at && !txn_own, txn && c == ready_at && txn_own});
      if (txn && c == ready_at) chk("rnd_rdata", txn_own ? d_rdata : i_rdata, mem_rdata);

      if (txn && c == ready_at) begin
        txn = 0; rel_at = c + 1; rel_own = txn_own; idle_at = c + 2;
        if (txn_own) dp = 0; else ip = 0;
      end else if (!txn && c >= idle_at && (ip || dp)) begin
        if (ip && dp) begin
          txn_own = (mcnt != int'(SMAX));
          mcnt = txn_own ? ((mcnt + 1 > int'(SMAX)) ? int'(SMAX) : mcnt + 1) : 0;
        end else begin
          txn_own = dp;
          if (!dp) mcnt = 0;
        end
        txn      = 1;
        txn_wr   = txn_own ? d_w : i_w;
        txn_addr = txn_own ? d_addr : i_addr;
        txn_wd   = txn_own ? d_wdata : i_wdata;
        ready_at = c + 1 + int'($urandom_range(0, 3));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
